// File: rtl/fp16_pkg.sv
// Shared definitions for the fp16 multiply sequencer: field widths, bias, special constants,
// FSM state encoding and flag bit positions.
// No logic; imported by the interface, the sequencer and its shift-add datapath.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int WORD_W = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;          // significand including hidden bit
    localparam int PROD_W = 2 * SIG_W;          // full significand product
    localparam int CNT_W  = $clog2(SIG_W);      // shift-add step counter
    localparam int E_W    = EXP_W + 2;          // signed working exponent
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

    localparam logic [WORD_W-1:0] FP16_QNAN    = 16'h7E00;
    localparam logic [EXP_W-1:0]  FP16_INF_EXP = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FLAG_W       = 4;
    localparam int FLAG_INVALID = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT = 0;

endpackage

// File: rtl/fp16_mul_sequencer_if.sv
// Operand/result handshake bundle for the fp16 multiply sequencer.
// slave: the sequencer (drives in_ready, out_valid, result, flags, busy).
// master: the operand producer / result consumer side.
interface fp16_mul_sequencer_if;
    import fp16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic              busy;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, result, flags, busy
    );

endinterface

// File: rtl/fp16_mant_shiftadd.sv
// Serial 11x11 significand multiplier: one conditional add of (ma << shamt) per step.
// Ports: load (capture ma/mb, clear P), step (one add/shift), shamt (step index), prod (P).
// No handshake; the sequencer owns timing and issues exactly SIG_W steps after a load.
module fp16_mant_shiftadd
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [SIG_W-1:0]  ma_in,
    input  logic [SIG_W-1:0]  mb_in,
    input  logic [CNT_W-1:0]  shamt,
    output logic [PROD_W-1:0] prod
);

    logic [SIG_W-1:0]  ma_q;
    logic [SIG_W-1:0]  mb_q;
    logic [PROD_W-1:0] p_q;
    logic [PROD_W-1:0] addend;

    // Multiplier bits are consumed LSB first, so the partial product weight is the step index.
    always_comb begin
        addend = '0;
        if (mb_q[0]) begin
            addend = {{(PROD_W-SIG_W){1'b0}}, ma_q} << shamt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_q <= '0;
            mb_q <= '0;
            p_q  <= '0;
        end else if (load) begin
            ma_q <= ma_in;
            mb_q <= mb_in;
            p_q  <= '0;
        end else if (step) begin
            p_q  <= p_q + addend;
            mb_q <= mb_q >> 1;
        end
    end

    assign prod = p_q;

endmodule

// File: rtl/fp16_mul_sequencer.sv
// Multi-cycle fp16 multiply: accept in IDLE, 11 shift-add steps, 1 normalize cycle, hold in DONE.
// Latency: out_valid rises 13 cycles after the accept cycle, for every operand class.
// Backpressure: result/flags held in DONE until out_ready; in_ready only in IDLE.
module fp16_mul_sequencer
    import fp16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fp16_mul_sequencer_if.slave  bus
);

    localparam logic signed [E_W-1:0] E_OVF  = E_W'(FP16_INF_EXP);
    localparam logic signed [E_W-1:0] E_UNF  = '0;
    localparam logic        [E_W-1:0] E_BIAS = E_W'(BIAS);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                last_step;
    logic                load;
    logic                step;

    logic                sign_q;
    logic [EXP_W-1:0]    ea_q;
    logic [EXP_W-1:0]    eb_q;
    logic [PROD_W-1:0]   prod;

    logic signed [E_W-1:0] e_sum;
    logic signed [E_W-1:0] e_adj;
    logic [MAN_W-1:0]    man;
    logic                sticky;
    logic                any_inf;
    logic                any_zero;

    logic [WORD_W-1:0]   result_q;
    logic [WORD_W-1:0]   result_nxt;
    logic [FLAG_W-1:0]   flags_q;
    logic [FLAG_W-1:0]   flags_nxt;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_step = (cnt == CNT_W'(SIG_W - 1));

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = MUL;
            MUL:     if (last_step)     state_nxt = NORM;
            NORM:                       state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        load          = 1'b0;
        step          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                load         = bus.in_valid;
            end
            MUL: begin
                bus.busy = 1'b1;
                step     = 1'b1;
            end
            NORM:    bus.busy      = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- operand capture and step counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            ea_q   <= '0;
            eb_q   <= '0;
            cnt    <= '0;
        end else if (load) begin
            sign_q <= bus.op_a[WORD_W-1] ^ bus.op_b[WORD_W-1];
            ea_q   <= bus.op_a[MAN_W +: EXP_W];
            eb_q   <= bus.op_b[MAN_W +: EXP_W];
            cnt    <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    fp16_mant_shiftadd u_shiftadd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .ma_in ({1'b1, bus.op_a[MAN_W-1:0]}),
        .mb_in ({1'b1, bus.op_b[MAN_W-1:0]}),
        .shamt (cnt),
        .prod  (prod)
    );

    // ---------------- normalize, truncate, special values ----------------
    always_comb begin
        e_sum    = $signed(E_W'({2'b00, ea_q}) + E_W'({2'b00, eb_q}) - E_BIAS);
        any_inf  = (ea_q == FP16_INF_EXP) || (eb_q == FP16_INF_EXP);
        any_zero = (ea_q == '0) || (eb_q == '0);

        // Product of two [1,2) significands lies in [1,4); top bit set means the [2,4) case.
        if (prod[PROD_W-1]) begin
            man    = prod[PROD_W-2 -: MAN_W];
            sticky = |prod[PROD_W-MAN_W-2:0];
            e_adj  = e_sum + E_W'(1);
        end else begin
            man    = prod[PROD_W-3 -: MAN_W];
            sticky = |prod[PROD_W-MAN_W-3:0];
            e_adj  = e_sum;
        end

        result_nxt = {sign_q, e_adj[EXP_W-1:0], man};
        flags_nxt  = '0;
        if (any_inf && any_zero) begin
            result_nxt                = FP16_QNAN;
            flags_nxt[FLAG_INVALID]   = 1'b1;
        end else if (any_inf) begin
            result_nxt = {sign_q, FP16_INF_EXP, {MAN_W{1'b0}}};
        end else if (any_zero) begin
            // Subnormal inputs are flushed, so a zero exponent field means a zero operand.
            result_nxt = {sign_q, {(EXP_W+MAN_W){1'b0}}};
        end else if (e_adj >= E_OVF) begin
            result_nxt                = {sign_q, FP16_INF_EXP, {MAN_W{1'b0}}};
            flags_nxt[FLAG_OVERFLOW]  = 1'b1;
            flags_nxt[FLAG_INEXACT]   = 1'b1;
        end else if (e_adj <= E_UNF) begin
            result_nxt                = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            flags_nxt[FLAG_UNDERFLOW] = 1'b1;
            flags_nxt[FLAG_INEXACT]   = 1'b1;
        end else begin
            flags_nxt[FLAG_INEXACT]   = sticky;
        end
    end

    // Result registers load only in NORM, so they hold through DONE and idle afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (state == NORM) begin
            result_q <= result_nxt;
            flags_q  <= flags_nxt;
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_fp16_mul_sequencer.sv
// Scoreboard bench for fp16_mul_sequencer: directed vectors with literal expectations,
// randomized operands checked against an arithmetic reference model, backpressure and
// mid-operation reset scenarios. A negedge monitor compares every result handed off.
`timescale 1ns/1ps
module tb_fp16_mul_sequencer;
    import fp16_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp16_mul_sequencer_if bif();

    fp16_mul_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [19:0] exp_q[$];   // {result, flags}
    int          acc_q[$];   // edge count of the accepting clock edge
    bit          rand_rdy = 1'b0;
    bit          ov_prev  = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Reference: exact integer product of the significands, then the normalize/special rules.
    function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int          ea, eb, e;
        int unsigned p;
        logic        s;
        logic [9:0]  m;
        bit          inexact;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        p  = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
        if (p >= 2097152) begin
            e = ea + eb - 15 + 1;
            m = 10'((p / 2048) % 1024);
            inexact = (p % 2048) != 0;
        end else begin
            e = ea + eb - 15;
            m = 10'((p / 1024) % 1024);
            inexact = (p % 1024) != 0;
        end
        if ((ea == 31 || eb == 31) && (ea == 0 || eb == 0)) return {16'h7E00, 4'b1000};
        if (ea == 31 || eb == 31) return {s, 5'h1F, 10'h000, 4'b0000};
        if (ea == 0 || eb == 0)   return {s, 15'h0000, 4'b0000};
        if (e >= 31)              return {s, 5'h1F, 10'h000, 4'b0101};
        if (e <= 0)               return {s, 15'h0000, 4'b0011};
        return {s, 5'(e), m, 3'b000, inexact};
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [19:0] want);
        int n = 0;
        @(posedge clk); #1;
        bif.in_valid = 1'b1;
        bif.op_a     = a;
        bif.op_b     = b;
        @(negedge clk);
        while (!bif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bif.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0, want 1");
            bif.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(want);
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.op_a     = 16'($urandom);
        bif.op_b     = 16'($urandom);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Random consumer, active only while rand_rdy is set.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) bif.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: on each new result check latency and value; pop on handoff.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (bif.out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h, want no result", bif.result);
                end else begin
                    chk("latency", 32'(cyc - acc_q[0]), 32'd12);
                    chk("result", 32'(bif.result), 32'(exp_q[0][19:4]));
                    chk("flags", 32'(bif.flags), 32'(exp_q[0][3:0]));
                end
            end
            if (bif.out_valid && bif.out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            ov_prev = bif.out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] dir_a [9] = '{16'h3E00, 16'h3C01, 16'h7BFF, 16'h8400, 16'h7C00,
                               16'hFC00, 16'h0001, 16'h0000, 16'h4000};
    logic [15:0] dir_b [9] = '{16'h3E00, 16'h3C01, 16'h4000, 16'h3800, 16'h0000,
                               16'h4000, 16'h3C00, 16'h7C00, 16'h4000};
    logic [19:0] dir_e [9] = '{{16'h4080, 4'h0}, {16'h3C02, 4'h1}, {16'h7C00, 4'h5},
                               {16'h8000, 4'h3}, {16'h7E00, 4'h8}, {16'hFC00, 4'h0},
                               {16'h0000, 4'h0}, {16'h7E00, 4'h8}, {16'h4400, 4'h0}};

    initial begin
        logic [15:0] a, b;
        int n;
        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.op_a      = '0;
        bif.op_b      = '0;
        bif.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_result", 32'(bif.result), 32'd0);
        chk("rst_flags", 32'(bif.flags), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1.0 * 1.0 with cycle-by-cycle busy/out_valid timing.
        issue(16'h3C00, 16'h3C00, {16'h3C00, 4'h0});
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("busy_t%0d", i + 1), 32'(bif.busy), (i < 12) ? 32'd1 : 32'd0);
            chk($sformatf("out_valid_t%0d", i + 1), 32'(bif.out_valid), (i == 12) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 9; i++) issue(dir_a[i], dir_b[i], dir_e[i]);
        drain("drain_directed");

        // Random operands, random consumer readiness and random idle gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                a = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
                b = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
            end else begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
            issue(a, b, ref_mul(a, b));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain("drain_random");
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;

        // Backpressure: result held, no second accept while the consumer stalls.
        issue(16'h3E00, 16'h3E00, {16'h4080, 4'h0});
        n = 0;
        @(negedge clk);
        while (!bif.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 32'(bif.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bif.in_valid = 1'b1;
            bif.op_a     = 16'($urandom);
            bif.op_b     = 16'($urandom);
            @(negedge clk);
            chk("bp_result", 32'(bif.result), 32'h4080);
            chk("bp_flags", 32'(bif.flags), 32'h0);
            chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bif.out_valid), 32'd1);
        end
        @(posedge clk); #1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bif.in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(bif.out_valid), 32'd0);
        chk("bp_release_busy", 32'(bif.busy), 32'd0);
        chk("bp_result_held", 32'(bif.result), 32'h4080);
        drain("drain_bp");

        // Reset during MUL step 5 discards the operation.
        issue(16'h3C00, 16'h3C00, {16'h3C00, 4'h0});
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("mid_rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bif.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bif.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_result_after_reset", 32'(bif.out_valid), 32'd0);

        issue(16'h4000, 16'h4000, {16'h4400, 4'h0});
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
